// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, next-PC
// select codes, the NOOP word and a sign-extension helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } state_t;

    localparam logic [1:0] PCSRC_SEQ  = 2'b00;
    localparam logic [1:0] PCSRC_BR   = 2'b01;
    localparam logic [1:0] PCSRC_JMP  = 2'b10;
    localparam logic [1:0] PCSRC_HOLD = 2'b11;

    localparam logic [31:0] NOOP = 32'h0000_0000;

    // Word offset from an I-type imm16 widened to PC width.
    function automatic logic signed [31:0] sext16(input logic signed [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/fetch_npc.sv
// Next-PC selection for the fetch stage. Purely combinational.
// Ports:
//   i_pc         current word-indexed PC
//   i_pc_src     select: SEQ (PC+1), BR (PC+1+offset), JMP (region jump), HOLD
//   i_branch_off signed branch offset in words
//   i_jump_tgt   26-bit jump target in words
//   o_npc        selected next PC (modulo 2^32)
//   o_pc_plus1   PC+1
module fetch_npc
    import fetch_pkg::*;
(
    input  logic        [31:0] i_pc,
    input  logic        [1:0]  i_pc_src,
    input  logic signed [15:0] i_branch_off,
    input  logic        [25:0] i_jump_tgt,
    output logic        [31:0] o_npc,
    output logic        [31:0] o_pc_plus1
);

    logic [31:0] w_pc_plus1;
    logic [31:0] w_branch_tgt;

    assign w_pc_plus1   = i_pc + 32'd1;
    // Unsigned add of the sign-extended offset wraps exactly like a signed add.
    assign w_branch_tgt = w_pc_plus1 + 32'(sext16(i_branch_off));
    assign o_pc_plus1   = w_pc_plus1;

    always_comb begin
        o_npc = i_pc;
        case (i_pc_src)
            PCSRC_SEQ:  o_npc = w_pc_plus1;
            PCSRC_BR:   o_npc = w_branch_tgt;
            // Jumps stay inside the current 2^26-word region.
            PCSRC_JMP:  o_npc = {i_pc[31:26], i_jump_tgt};
            PCSRC_HOLD: o_npc = i_pc;
            default:    o_npc = i_pc;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage of the multi-cycle CPU. Owns the PC, latches the instruction
// returned by the combinational instruction memory into IR after FETCH_LAT
// cycles, and offers it to decode over a valid/ready handshake. Next-PC
// commits happen only on pc_update pulses from control.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   fetch_req    level request to start a fetch from S_IDLE
//   PC           registered PC to instruction memory
//   Instruction  memory read data for PC
//   IR, ir_valid latched instruction and its valid flag
//   ir_ready     decode accepts IR
//   pc_update    commit next PC selected by pc_src/branch_off/jump_tgt
//   PCPlus1      PC+1 for link/debug
//   upd_drop     sticky flag: a pc_update was ignored during a fetch
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int          FETCH_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    output logic [31:0] PC,
    input  logic [31:0] Instruction,
    output logic [31:0] IR,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        pc_update,
    input  logic [1:0]  pc_src,
    input  logic [15:0] branch_off,
    input  logic [25:0] jump_tgt,
    output logic [31:0] PCPlus1,
    output logic        upd_drop
);

    generate
        if (FETCH_LAT < 1 || FETCH_LAT > 15) begin : g_bad_lat
            $error("fetch_unit: FETCH_LAT must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] CNT_LOAD = 4'(FETCH_LAT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic        r_ir_valid;
    logic        r_upd_drop;

    logic [31:0] w_npc;
    logic [31:0] w_pc_plus1;

    logic        w_pc_commit;
    logic        w_fetch_start;
    logic        w_capture;
    logic        w_accept;
    logic        w_drop;

    fetch_npc u_npc (
        .i_pc         (r_pc),
        .i_pc_src     (pc_src),
        .i_branch_off (branch_off),
        .i_jump_tgt   (jump_tgt),
        .o_npc        (w_npc),
        .o_pc_plus1   (w_pc_plus1)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; pc_update wins over fetch_req in S_IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (!pc_update && fetch_req) w_next_state = S_FETCH;
            S_FETCH: if (r_cnt == 4'd0)           w_next_state = S_VALID;
            S_VALID: if (ir_ready)                w_next_state = S_IDLE;
            default:                              w_next_state = S_IDLE;
        endcase
    end

    // Per-state control strobes for the datapath registers.
    always_comb begin
        w_pc_commit   = 1'b0;
        w_fetch_start = 1'b0;
        w_capture     = 1'b0;
        w_accept      = 1'b0;
        w_drop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pc_commit   = pc_update;
                w_fetch_start = !pc_update && fetch_req;
            end
            S_FETCH: begin
                // PC is frozen while memory is being read.
                w_capture = (r_cnt == 4'd0);
                w_drop    = pc_update;
            end
            S_VALID: begin
                w_pc_commit = pc_update;
                w_accept    = ir_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_ir       <= NOOP;
            r_ir_valid <= 1'b0;
            r_upd_drop <= 1'b0;
            r_cnt      <= 4'd0;
        end else begin
            if (w_pc_commit) begin
                r_pc <= w_npc;
            end

            if (w_fetch_start) begin
                r_cnt <= CNT_LOAD;
            end else if (r_state == S_FETCH && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_capture) begin
                r_ir       <= Instruction;
                r_ir_valid <= 1'b1;
            end else if (w_accept) begin
                r_ir_valid <= 1'b0;
            end

            if (w_drop) begin
                r_upd_drop <= 1'b1;
            end
        end
    end

    assign PC       = r_pc;
    assign IR       = r_ir;
    assign ir_valid = r_ir_valid;
    assign PCPlus1  = w_pc_plus1;
    assign upd_drop = r_upd_drop;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int N = 3;
    localparam int LAT [N] = '{1, 4, 2};
    localparam logic [31:0] RPC [N] = '{32'h0, 32'h0, 32'h0400001D};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn [N];
    logic        fr   [N];
    logic        pu   [N];
    logic        rdy  [N];
    logic [1:0]  src  [N];
    logic [15:0] off  [N];
    logic [25:0] tgt  [N];
    logic [31:0] pco  [N];
    logic [31:0] iro  [N];
    logic [31:0] pp1  [N];
    logic [31:0] ins  [N];
    logic        vo   [N];
    logic        dro  [N];

    int n_chk  = 0;
    int n_fail = 0;

    function automatic logic [31:0] imem(input logic [31:0] pc);
        if (pc == 32'd0) return 32'h0;
        if (pc == 32'd1) return 32'hC8210005;
        return {pc[15:0] ^ 16'h5A5A, pc[15:0]};
    endfunction

    assign ins[0] = imem(pco[0]);
    assign ins[1] = imem(pco[1]);
    assign ins[2] = imem(pco[2]);

    fetch_unit #(.RESET_PC(32'h0), .FETCH_LAT(1)) u0 (
        .clk(clk), .rst_n(rstn[0]), .fetch_req(fr[0]), .PC(pco[0]),
        .Instruction(ins[0]), .IR(iro[0]), .ir_valid(vo[0]), .ir_ready(rdy[0]),
        .pc_update(pu[0]), .pc_src(src[0]), .branch_off(off[0]),
        .jump_tgt(tgt[0]), .PCPlus1(pp1[0]), .upd_drop(dro[0]));

    fetch_unit #(.RESET_PC(32'h0), .FETCH_LAT(4)) u1 (
        .clk(clk), .rst_n(rstn[1]), .fetch_req(fr[1]), .PC(pco[1]),
        .Instruction(ins[1]), .IR(iro[1]), .ir_valid(vo[1]), .ir_ready(rdy[1]),
        .pc_update(pu[1]), .pc_src(src[1]), .branch_off(off[1]),
        .jump_tgt(tgt[1]), .PCPlus1(pp1[1]), .upd_drop(dro[1]));

    fetch_unit #(.RESET_PC(32'h0400001D), .FETCH_LAT(2)) u2 (
        .clk(clk), .rst_n(rstn[2]), .fetch_req(fr[2]), .PC(pco[2]),
        .Instruction(ins[2]), .IR(iro[2]), .ir_valid(vo[2]), .ir_ready(rdy[2]),
        .pc_update(pu[2]), .pc_src(src[2]), .branch_off(off[2]),
        .jump_tgt(tgt[2]), .PCPlus1(pp1[2]), .upd_drop(dro[2]));

    // Behavioural model: edges-left-in-fetch counter plus architectural values.
    logic [31:0] m_pc   [N];
    logic [31:0] m_ir   [N];
    bit          m_v    [N];
    bit          m_d    [N];
    int          m_busy [N];
    bit          en     [N] = '{0, 0, 0};

    function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic [1:0] s,
                                              input logic [15:0] o, input logic [25:0] t);
        longint so;
        so = longint'($signed(o));
        case (s)
            2'b00:   return 32'(pc + 1);
            2'b01:   return 32'(longint'(pc) + 1 + so);
            2'b10:   return (pc & 32'hFC00_0000) | {6'b0, t};
            default: return pc;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (!rstn[k]) begin
                m_pc[k] = RPC[k]; m_ir[k] = 32'h0; m_v[k] = 0; m_d[k] = 0;
                m_busy[k] = 0; en[k] = 1;
            end else if (m_busy[k] > 0) begin
                if (pu[k]) m_d[k] = 1;
                m_busy[k] = m_busy[k] - 1;
                if (m_busy[k] == 0) begin
                    m_ir[k] = imem(m_pc[k]);
                    m_v[k]  = 1;
                end
            end else if (m_v[k]) begin
                if (rdy[k]) m_v[k] = 0;
                if (pu[k]) m_pc[k] = model_npc(m_pc[k], src[k], off[k], tgt[k]);
            end else begin
                if (pu[k]) m_pc[k] = model_npc(m_pc[k], src[k], off[k], tgt[k]);
                else if (fr[k]) m_busy[k] = LAT[k];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (en[k]) begin
                chk($sformatf("u%0d.PC", k), pco[k], m_pc[k]);
                chk($sformatf("u%0d.IR", k), iro[k], m_ir[k]);
                chk($sformatf("u%0d.ir_valid", k), {31'b0, vo[k]}, {31'b0, m_v[k]});
                chk($sformatf("u%0d.upd_drop", k), {31'b0, dro[k]}, {31'b0, m_d[k]});
                chk($sformatf("u%0d.PCPlus1", k), pp1[k], 32'(m_pc[k] + 1));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic upd(input int k, input logic [1:0] s, input logic [15:0] o, input logic [25:0] t);
        pu[k] = 1'b1; src[k] = s; off[k] = o; tgt[k] = t;
        tick(1);
        pu[k] = 1'b0; src[k] = 2'b11;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            rstn[k] = 0; fr[k] = 0; pu[k] = 0; rdy[k] = 0;
            src[k] = 2'b11; off[k] = 16'h0; tgt[k] = 26'h0;
        end
        tick(2);
        chk("reset PC", pco[0], 32'h0);
        chk("reset IR", iro[0], 32'h0);
        chk("reset ir_valid", {31'b0, vo[0]}, 32'h0);
        chk("reset upd_drop", {31'b0, dro[0]}, 32'h0);
        chk("reset PC u2", pco[2], 32'h0400001D);
        for (int k = 0; k < N; k++) rstn[k] = 1;
        tick(1);

        // Fetch with FETCH_LAT=1 at PC=0
        fr[0] = 1; tick(1); fr[0] = 0;
        chk("t1 valid after 1 edge", {31'b0, vo[0]}, 32'h0);
        tick(1);
        chk("t1 valid after 2 edges", {31'b0, vo[0]}, 32'h1);
        chk("t1 IR", iro[0], 32'h0);
        rdy[0] = 1; tick(1); rdy[0] = 0;
        chk("t1 accepted", {31'b0, vo[0]}, 32'h0);

        // Branches
        upd(0, 2'b10, 16'h0, 26'd14); chk("t2 jmp 14", pco[0], 32'd14);
        upd(0, 2'b01, 16'hFFF1, 26'h0); chk("t2 br back", pco[0], 32'd0);
        upd(0, 2'b10, 16'h0, 26'd15);
        upd(0, 2'b01, 16'h0001, 26'h0); chk("t2 br fwd", pco[0], 32'd17);

        // Jumps
        upd(0, 2'b10, 16'h0, 26'd29); chk("t3 set 29", pco[0], 32'd29);
        upd(0, 2'b10, 16'h0, 26'h0); chk("t3 jmp 0", pco[0], 32'd0);
        upd(2, 2'b10, 16'h0, 26'd5); chk("t3 jmp region", pco[2], 32'h04000005);

        // Long fetch, stall, update in S_VALID, accept
        upd(1, 2'b10, 16'h0, 26'd1);
        fr[1] = 1; tick(1); fr[1] = 0;
        chk("t4 wait 1", {31'b0, vo[1]}, 32'h0);
        for (int i = 2; i <= 4; i++) begin
            tick(1);
            chk($sformatf("t4 wait %0d", i), {31'b0, vo[1]}, 32'h0);
        end
        tick(1);
        chk("t4 valid", {31'b0, vo[1]}, 32'h1);
        chk("t4 IR", iro[1], 32'hC8210005);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("t4 stall IR", iro[1], 32'hC8210005);
            chk("t4 stall valid", {31'b0, vo[1]}, 32'h1);
        end
        upd(1, 2'b00, 16'h0, 26'h0);
        chk("t4 upd in valid PC", pco[1], 32'd2);
        chk("t4 upd in valid IR", iro[1], 32'hC8210005);
        chk("t4 upd in valid v", {31'b0, vo[1]}, 32'h1);
        rdy[1] = 1; tick(1); rdy[1] = 0;
        chk("t4 accepted", {31'b0, vo[1]}, 32'h0);

        // Dropped update during fetch; ready+update together
        fr[1] = 1; tick(1); fr[1] = 0;
        upd(1, 2'b10, 16'h0, 26'd9);
        chk("t5 PC frozen", pco[1], 32'd2);
        chk("t5 drop set", {31'b0, dro[1]}, 32'h1);
        tick(3);
        chk("t5 valid", {31'b0, vo[1]}, 32'h1);
        chk("t5 drop sticky", {31'b0, dro[1]}, 32'h1);
        rdy[1] = 1; upd(1, 2'b00, 16'h0, 26'h0); rdy[1] = 0;
        chk("t5 ready+upd PC", pco[1], 32'd3);
        chk("t5 ready+upd v", {31'b0, vo[1]}, 32'h0);

        // Reset mid-fetch
        upd(1, 2'b10, 16'h0, 26'd7);
        fr[1] = 1; tick(1); fr[1] = 0; tick(1);
        rstn[1] = 0; tick(1);
        chk("t6 rst PC", pco[1], 32'h0);
        chk("t6 rst IR", iro[1], 32'h0);
        chk("t6 rst v", {31'b0, vo[1]}, 32'h0);
        chk("t6 rst drop", {31'b0, dro[1]}, 32'h0);
        rstn[1] = 1; tick(5);
        chk("t6 fetch abandoned", {31'b0, vo[1]}, 32'h0);

        // Wrap and hold
        upd(0, 2'b01, 16'hFFFE, 26'h0); chk("t6 to FFFFFFFF", pco[0], 32'hFFFFFFFF);
        chk("t6 PCPlus1 wrap", pp1[0], 32'h0);
        upd(0, 2'b00, 16'h0, 26'h0); chk("t6 wrap", pco[0], 32'h0);
        upd(0, 2'b11, 16'h1234, 26'h3FFFFFF); chk("hold", pco[0], 32'h0);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
